// File: rtl/req_pop_sched_pkg.sv
// Shared types and field positions for the request-pop scheduler.
// REQ_POP_TIMEOUT_EN adds the TOUT state used by the grant-wait timeout.
package axi_slave_package;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_LOCAL
`ifdef REQ_POP_TIMEOUT_EN
    , S_TOUT
`endif
  } req_pop_sched_state;

  localparam logic [2:0] LOCAL_CODE_DEF = 3'b011;
  localparam int CODE_LSB   = 0;
  localparam int CODE_W     = 3;
  localparam int ID_LSB_DEF = 60;
  localparam int ID_W_DEF   = 4;

endpackage

// File: rtl/req_pop_sched_if.sv
// FIFO-side, arbiter-side and local-completion signals of the scheduler.
// REQ_POP_TIMEOUT_EN adds the timeout_err flag.
interface req_pop_sched_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH-1:0]        fifo_rd_en;
  logic [NUM_CH*DATA_W-1:0] fifo_rd_data;
  logic                     req_valid;
  logic [DATA_W-1:0]        req_data;
  logic [CH_W-1:0]          req_ch;
  logic                     req_grant;
  logic                     local_valid;
  logic [ID_W-1:0]          local_id;
  logic                     local_ready;
`ifdef REQ_POP_TIMEOUT_EN
  logic                     timeout_err;
`endif

  modport master (
    input  fifo_empty, fifo_rd_data, req_grant, local_ready,
    output fifo_rd_en, req_valid, req_data, req_ch, local_valid, local_id
`ifdef REQ_POP_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport slave (
    output fifo_empty, fifo_rd_data, req_grant, local_ready,
    input  fifo_rd_en, req_valid, req_data, req_ch, local_valid, local_id
`ifdef REQ_POP_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/req_pop_sched_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at N.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  always_comb begin
    int   c;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = W'(c);
      end
    end
  end
endmodule

// File: rtl/req_pop_sched.sv
// Pops one FIFO entry at a time (round-robin) and offers it to the core arbiter,
// or completes it locally. REQ_POP_TIMEOUT_EN enables the grant-wait timeout.
module req_pop_sched
  import axi_slave_package::*;
#(
  parameter int         NUM_CH      = 2,
  parameter int         DATA_W      = 64,
  parameter int         ID_W        = ID_W_DEF,
  parameter int         ID_LSB      = ID_LSB_DEF,
  parameter logic [2:0] LOCAL_CODE  = LOCAL_CODE_DEF,
  parameter int         TIMEOUT_CYC = 256
) (
  input logic            CLK,
  input logic            ARESET,
  req_pop_sched_if.master bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  req_pop_sched_state state, nxt;
  logic [CH_W-1:0]    rr_ptr, sel, pick_idx;
  logic [NUM_CH-1:0]  pick_gnt;
  logic [DATA_W-1:0]  req_data_q, entry;
  logic [CH_W-1:0]    req_ch_q;
  logic               any_req, is_local, done;

  assign any_req  = |(~bus.fifo_empty);
  assign entry    = bus.fifo_rd_data[int'(sel)*DATA_W +: DATA_W];
  assign is_local = (entry[CODE_LSB +: CODE_W] == LOCAL_CODE);
  assign done     = (state == S_HOLD && bus.req_grant) || (state == S_LOCAL && bus.local_ready);

  rr_pick #(.N(NUM_CH), .W(CH_W)) u_rr (
    .req(~bus.fifo_empty), .ptr(rr_ptr), .gnt(pick_gnt), .idx(pick_idx)
  );

`ifdef REQ_POP_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CYC + 1);
  logic [TC_W-1:0] tcnt;
  logic            tc_hit;
  assign tc_hit = (tcnt == TC_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge ARESET)
    if (ARESET)                               tcnt <= '0;
    else if (state == S_HOLD && !bus.req_grant) tcnt <= tcnt + 1'b1;
    else                                      tcnt <= '0;
`endif

  always_ff @(posedge CLK or posedge ARESET)
    if (ARESET) state <= S_IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (any_req) nxt = S_FETCH;
      S_FETCH: nxt = is_local ? S_LOCAL : S_HOLD;
      S_HOLD:
        if (bus.req_grant) nxt = S_IDLE;
`ifdef REQ_POP_TIMEOUT_EN
        else if (tc_hit)   nxt = S_TOUT;
      S_TOUT:  nxt = S_TOUT;
`endif
      S_LOCAL: if (bus.local_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ARESET)
    if (ARESET) begin
      rr_ptr     <= '0;
      sel        <= '0;
      req_data_q <= '0;
      req_ch_q   <= '0;
    end else begin
      if (state == S_IDLE && any_req) sel <= pick_idx;
      if (state == S_FETCH) begin
        req_data_q <= entry;
        req_ch_q   <= sel;
      end
      if (done) rr_ptr <= (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
    end

  // rd_en is combinational from the picker, so reset must mask it explicitly
  always_comb begin
    bus.fifo_rd_en  = (state == S_IDLE && !ARESET) ? pick_gnt : '0;
    bus.req_valid   = (state == S_HOLD);
    bus.local_valid = (state == S_LOCAL);
    bus.local_id    = (state == S_LOCAL) ? req_data_q[ID_LSB +: ID_W] : '0;
    bus.req_data    = req_data_q;
    bus.req_ch      = req_ch_q;
`ifdef REQ_POP_TIMEOUT_EN
    bus.timeout_err = (state == S_TOUT);
`endif
  end
endmodule
